// File: rtl/arb_rr.sv
// ============================================================================
// Module   : arb_rr
// Brief    : Round-robin arbiter with registered one-hot grant and ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr_psel #(
    parameter int W        = 4,
    parameter int FROM_LSB = 1
) (
    input  logic [W-1:0]         i_vec,
    output logic [W-1:0]         o_sel,
    output logic [$clog2(W)-1:0] o_idx
);
    localparam int IW = $clog2(W);

    always_comb begin
        int  j;
        logic found;
        o_sel = '0;
        o_idx = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < W; i++) begin
            j = (FROM_LSB != 0) ? i : (W - 1 - i);
            if (!found && i_vec[j]) begin
                o_sel[j] = 1'b1;
                o_idx    = IW'(j);
                found    = 1'b1;
            end
        end
    end
endmodule

module arb_rr #(
    parameter int W        = 4,   // at least 2
    parameter int FROM_LSB = 1
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [W-1:0]         i_req,
    input  logic                 i_gnt_ack,
    output logic                 o_gnt_vld,
    output logic [W-1:0]         o_gnt,
    output logic [$clog2(W)-1:0] o_gnt_idx
);
    localparam int IW = $clog2(W);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    mask_q, mask_d;

    logic [W-1:0]    w_ack_mask;
    logic [W-1:0]    w_sel_mask;
    logic [W-1:0]    w_m_sel, w_u_sel, w_win_gnt;
    logic [IW-1:0]   w_m_idx, w_u_idx, w_win_idx;
    logic            w_ack;

    // Bits strictly after the presented index in scan direction, no wrap.
    always_comb begin
        w_ack_mask = '0;
        for (int i = 0; i < W; i++) begin
            w_ack_mask[i] = (FROM_LSB != 0) ? (i > int'(idx_q)) : (i < int'(idx_q));
        end
    end

    assign w_ack      = (state_q == GRANT) && i_gnt_ack;
    // On an ack the winner must see the mask as it is about to be updated.
    assign w_sel_mask = w_ack ? w_ack_mask : mask_q;

    arb_rr_psel #(.W(W), .FROM_LSB(FROM_LSB)) u_psel_masked (
        .i_vec (i_req & w_sel_mask),
        .o_sel (w_m_sel),
        .o_idx (w_m_idx)
    );

    arb_rr_psel #(.W(W), .FROM_LSB(FROM_LSB)) u_psel_unmasked (
        .i_vec (i_req),
        .o_sel (w_u_sel),
        .o_idx (w_u_idx)
    );

    assign w_win_gnt = (|w_m_sel) ? w_m_sel : w_u_sel;
    assign w_win_idx = (|w_m_sel) ? w_m_idx : w_u_idx;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_d = GRANT;
                    gnt_d   = w_win_gnt;
                    idx_d   = w_win_idx;
                end
            end
            GRANT: begin
                if (i_gnt_ack) begin
                    mask_d = w_ack_mask;
                    if (|w_win_gnt) begin
                        gnt_d = w_win_gnt;
                        idx_d = w_win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    assign o_gnt_vld = (state_q == GRANT);
    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;
endmodule

`default_nettype wire

// File: doc/arb_rr.md
ARB_RR -- requirements
Module: arb_rr

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter W, default 4: number of requesters, SHALL be at least 2.
REQ-003 Parameter FROM_LSB, default 1: scan direction. 1 means the next candidate after index k is k+1, wrapping to 0. 0 means k-1, wrapping to W-1.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port arst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port i_req, input, W bits: request vector; bit i set means requester i wants service.
REQ-007 Port o_gnt_vld, output, 1 bit: a grant is presented on o_gnt.
REQ-008 Port o_gnt, output, W bits: registered grant; one-hot when o_gnt_vld=1, all-zero otherwise.
REQ-009 Port o_gnt_idx, output, $clog2(W) bits: binary index of the set bit of o_gnt; 0 when o_gnt_vld=0.
REQ-010 Port i_gnt_ack, input, 1 bit: consumer accepts the presented grant; completes the handshake.

Function
REQ-011 The FSM SHALL have two states. IDLE: o_gnt_vld=0. GRANT: o_gnt_vld=1.
REQ-012 Selection SHALL use two priority-select instances over the same scan direction.
- Masked select: i_req & mask.
- Unmasked select: i_req.
- Winner: the masked result if it is non-zero, else the unmasked result.
REQ-013 mask SHALL hold the bits strictly after the last acknowledged index in scan direction, with no wrap.
- FROM_LSB=1, last index k: bits k+1..W-1.
- FROM_LSB=0, last index k: bits 0..k-1.
REQ-014 In IDLE, if i_req is non-zero, the FSM SHALL move to GRANT on the next edge and register the winner into o_gnt and o_gnt_idx; the latency is one cycle.
REQ-015 In IDLE with i_req=0, the FSM SHALL stay in IDLE and leave mask unchanged.
REQ-016 In GRANT, o_gnt and o_gnt_idx SHALL hold stable until the cycle in which i_gnt_ack=1.
REQ-017 The grant SHALL be sticky: deasserting the granted i_req bit while in GRANT SHALL NOT change or withdraw the grant.
REQ-018 On an ack cycle in GRANT, mask SHALL update from o_gnt_idx.
REQ-019 On an ack cycle, a winner SHALL be computed in the same cycle from the current i_req and the updated mask. If non-zero, the FSM stays in GRANT with the new grant registered, giving back-to-back grants with zero bubble. If zero, the FSM moves to IDLE.
REQ-020 i_gnt_ack while in IDLE SHALL be ignored and SHALL leave state and mask unchanged.
REQ-021 A single requester holding its request SHALL be regranted on every ack: masked select is empty, so unmasked select picks it.
REQ-022 When the last acknowledged index is the final bit in scan direction, mask SHALL be all-zero, so the next winner wraps to the first requesting bit.
REQ-023 Fairness: with all W requests held and ack every cycle, each index SHALL be granted exactly once in any W consecutive grants.
REQ-024 o_gnt SHALL never have more than one bit set; the verification bench SHALL assert this.

Reset
REQ-025 While arst_n=0, asynchronously:
- state=IDLE;
- o_gnt_vld=0, o_gnt=0, o_gnt_idx=0;
- mask=all-zero.
REQ-026 Reset asserted mid-grant SHALL drop o_gnt_vld immediately, without waiting for a clock edge; the pending grant is discarded and no ack is required.
REQ-027 After arst_n deasserts, the first grant SHALL come from unmasked select, i.e. the first requesting bit in scan direction.

Verification (W=4, FROM_LSB=1)
REQ-028 Reset release, i_req=4'b1010 held, no ack:
- next cycle: o_gnt=4'b0010, o_gnt_idx=1;
- the grant holds for 10 cycles unchanged.
REQ-029 i_req=4'b1111 held, i_gnt_ack=1 every cycle:
- o_gnt sequence 0001, 0010, 0100, 1000, 0001;
- o_gnt_vld stays 1 throughout.
REQ-030 Grant 4'b0100 presented, i_req changes to 4'b0001 before ack:
- o_gnt stays 0100 until ack;
- next cycle after ack: o_gnt=0001, the wrap case.
REQ-031 Only i_req[3] set, ack every cycle: o_gnt=4'b1000 on every cycle with o_gnt_vld=1.
REQ-032 Ack with i_req=0:
- next cycle: o_gnt_vld=0, o_gnt=0;
- a later i_req=4'b0001 gives the grant one cycle after it is applied.
REQ-033 arst_n pulsed low while o_gnt=4'b0100:
- o_gnt_vld=0 in the same cycle;
- after release with i_req=4'b1100, the first grant is 0100.
